// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 32-bit RISC core.
// Holds the architectural PC, issues word-addressed requests to instruction
// memory (req/ready) and presents the fetched word to decode (valid/ready).
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   -> 16-bit wait watchdog; stalling memory for TIMEOUT_CYCLES
//                wait cycles sets sticky fetch_err and parks in ERR.
//   undefined -> no watchdog, fetch_err tied low, memory may stall forever.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   next_pc             next fetch address, sampled only when a new fetch launches
//   flush               discard held / in-flight instruction, refetch from next_pc
//   imem_req/imem_addr  memory request and word address (stable while req high)
//   imem_ready/rdata    memory completion and instruction word
//   instr/instr_valid   fetched instruction to decode
//   instr_ready         decode accepts instr
//   pc                  address of instr
//   fetch_err           sticky memory-timeout flag
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DROP,
        S_HOLD
`ifdef FETCH_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t state;
    state_t state_n;
    logic   load_addr;   // launch a new fetch from next_pc
    logic   capture;     // accept memory data into instr/pc
    logic   waiting;     // outstanding request with memory not ready

    assign waiting = ((state == S_REQ) || (state == S_DROP)) && !imem_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    // The wait cycle that would bring the count to TIMEOUT_CYCLES trips the watchdog
    assign timeout = waiting && (wait_cnt == TO_LAST);

    // Wait counter: counts consecutive not-ready cycles of an outstanding request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^(16'(TIMEOUT_CYCLES));
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n   = state;
        load_addr = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (imem_ready) begin
                    if (flush) begin
                        load_addr = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_n = S_HOLD;
                    end
                end else if (flush) begin
                    state_n = S_DROP;
                end
            end
            S_DROP: begin
                // Outstanding request must complete before its data is discarded
                if (imem_ready) begin
                    load_addr = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush || instr_ready) begin
                    load_addr = 1'b1;
                    state_n   = S_REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: begin
                state_n = S_ERR;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (timeout) begin
            state_n   = S_ERR;
            load_addr = 1'b0;
            capture   = 1'b0;
        end
`endif
    end

    // Registered handshake outputs follow the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            imem_req    <= (state_n == S_REQ) || (state_n == S_DROP);
            instr_valid <= (state_n == S_HOLD);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Sticky: ERR is only left through reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= (state_n == S_ERR);
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    // Fetch address register; no arithmetic, next_pc is used as given
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_addr <= '0;
        end else if (state == S_IDLE) begin
            imem_addr <= RESET_PC;
        end else if (load_addr) begin
            imem_addr <= next_pc;
        end
    end

    // Instruction / PC capture, held stable while in HOLD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
            pc    <= RESET_PC;
        end else if (capture) begin
            instr <= XLEN'(imem_rdata);
            pc    <= imem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. A transaction-level model
// tracks the current fetch address and held instruction; expected transfers to
// decode are queued by the driver and checked by an independent monitor.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned TO     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc = '0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic        fetch_err;

    instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Model: ph 0 = just out of reset, 1 = request outstanding, 2 = holding, 3 = error
    int          ph = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic        doomed = 1'b0;
    int          m_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops an expectation whenever decode actually takes an instruction
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && instr_valid === 1'b1 && instr_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer_unexpected: got pc=%h instr=%h with nothing expected", pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", pc, e.a);
                    chk("xfer_instr", instr, e.d);
                end
            end
        end
    end

    task automatic check_outputs();
        chk("imem_req", 32'(imem_req), 32'(ph == 1));
        if (ph == 1) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", 32'(instr_valid), 32'(ph == 2));
        if (ph == 2) begin
            chk("hold_pc", pc, m_pc);
            chk("hold_instr", instr, m_instr);
        end
        chk("fetch_err", 32'(fetch_err), 32'(ph == 3));
    endtask

    // One clock: apply inputs, advance model by the fetch rules, compare
    task automatic step(input logic fl, input logic ir, input logic mr,
                        input logic [31:0] np, input logic [31:0] rd);
        xfer_t e;
        if (ph == 2 && ir && !fl) begin
            e.a = m_pc;
            e.d = m_instr;
            exp_q.push_back(e);
        end
        flush = fl; instr_ready = ir; imem_ready = mr; next_pc = np; imem_rdata = rd;
        @(posedge clk);
        @(negedge clk);
        case (ph)
            0: begin
                ph = 1; m_addr = RST_PC; doomed = 1'b0; m_wait = 0;
            end
            1: begin
                if (mr) begin
                    m_wait = 0;
                    if (fl || doomed) begin
                        m_addr = np; doomed = 1'b0;
                    end else begin
                        ph = 2; m_pc = m_addr; m_instr = rd;
                    end
                end else begin
                    if (fl) doomed = 1'b1;
                    m_wait++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait == int'(TO)) ph = 3;
`endif
                end
            end
            2: begin
                if (fl || ir) begin
                    ph = 1; m_addr = np; doomed = 1'b0;
                end
            end
            default: ;
        endcase
        check_outputs();
    endtask

    task automatic do_reset();
        flush = 1'b0; instr_ready = 1'b0; imem_ready = 1'b0; next_pc = '0; imem_rdata = '0;
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_req", 32'(imem_req), 32'h0);
        chk("rst_async_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        ph = 0; doomed = 1'b0; m_wait = 0;
        exp_q.delete();
    endtask

    task automatic rand_step();
        logic        fl, ir, mr;
        logic [31:0] np;
        fl = ($urandom_range(0, 7) == 0);
        ir = ($urandom_range(0, 2) != 0);
        mr = (m_wait >= 2) || ($urandom_range(0, 1) == 1);
        np = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        step(fl, ir, mr, np, 32'($urandom));
    endtask

    initial begin
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("first_addr", imem_addr, RST_PC);

        // Zero-wait stream, decode always ready, sequential addresses
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, m_pc + 32'd1, 32'($urandom));
        chk("seq_addr", imem_addr, RST_PC + 32'd4);

        // Decode stalls for 5 cycles on a held instruction
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'($urandom), 32'($urandom));
            chk("stall_instr", instr, 32'hDEAD_BEEF);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        chk("after_stall_addr", imem_addr, 32'h200);

        // Flush during a stalled request; response is discarded
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        chk("drop_valid", 32'(instr_valid), 32'h0);
        chk("drop_addr", imem_addr, 32'h40);

        // Flush and instr_ready together in HOLD: flush wins
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001);
        step(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        chk("flush_hold_valid", 32'(instr_valid), 32'h0);
        chk("flush_hold_addr", imem_addr, 32'h80);

        // All-ones next_pc is fetched as-is
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h5555_AAAA);
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);

        // Reset while a request is outstanding
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_refetch_addr", imem_addr, RST_PC);

        for (int i = 0; i < 3000; i++) rand_step();

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: memory never answers
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < int'(TO); i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("to_err", 32'(fetch_err), 32'h1);
        chk("to_req", 32'(imem_req), 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h44, 32'h0);
        chk("to_err_sticky", 32'(fetch_err), 32'h1);
        do_reset();
        chk("to_err_cleared", 32'(fetch_err), 32'h0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
